imem_loader: RTL and testbench

- Writer side of the instruction memory: receives a program as a byte stream and writes it, one 32-bit word at a time, into the instruction memory write port.
- Sits between the host/UART byte source and the instruction memory.
- Holds the core in stall (busy) while a load is in progress.
- Bytes arrive little-endian per word; words are written at consecutive word addresses starting at 0.

---
 rtl/imem_pkg.sv | 15 +
 rtl/byte_to_word_packer.sv | 33 +++
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory loader: depth default, word width,
// header length and the loader FSM state encodings.
package imem_pkg;

  localparam int NUM_INST_DEF = 128;
  localparam int WORD_W       = 32;
  localparam int HDR_LEN      = 2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/byte_to_word_packer.sv
// Collects four little-endian bytes; word_valid pulses combinationally on the
// fourth byte so the caller can register the write in the same edge.
module byte_to_word_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]  cnt;
  logic [23:0] acc;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= 2'd0;
      acc <= 24'd0;
    end else if (byte_valid) begin
      cnt <= cnt + 2'd1;
      if (cnt != 2'd3) begin
        acc[{cnt, 3'b000} +: 8] <= byte_data;
      end
    end
  end

  assign word_valid = byte_valid && (cnt == 2'd3);
  assign word       = {byte_data, acc};

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory; holds the core in busy
// while loading. Optional trailing XOR checksum under IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int NUM_INST = NUM_INST_DEF,
  parameter int ADDR_W   = $clog2(NUM_INST)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded,
  output logic [2:0]        state
);

  localparam logic [16:0] NUM_LIM = 17'(NUM_INST);

  logic [15:0]       n_words;
  logic [15:0]       word_idx;
  logic              byte_fire;
  logic              in_stream;
  logic              word_valid;
  logic [WORD_W-1:0] word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign in_stream = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
`else
  assign in_stream = (state == ST_HDR) || (state == ST_DATA);
`endif

  // A byte is transferred only when s_valid && s_ready; s_valid alone is never consumed.
  assign s_ready   = in_stream;
  assign busy      = in_stream;
  assign done      = (state == ST_DONE);
  assign byte_fire = s_valid && s_ready;

  byte_to_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state == ST_IDLE),
    .byte_valid (byte_fire && (state == ST_DATA)),
    .byte_data  (s_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      n_words      <= 16'd0;
      word_idx     <= 16'd0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      err          <= 1'b0;
      words_loaded <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_HDR;
            err          <= 1'b0;
            words_loaded <= 16'd0;
            word_idx     <= 16'd0;
            n_words      <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= 8'd0;
`endif
          end
        end
        ST_HDR: begin
          if (byte_fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ s_data;
`endif
            // Shift right so the first header byte ends up as the LSB.
            n_words <= {s_data, n_words[15:8]};
            if (word_idx == 16'(HDR_LEN - 1)) begin
              word_idx <= 16'd0;
              state    <= ({s_data, n_words[15:8]} == 16'd0) ? ST_DONE : ST_DATA;
            end else begin
              word_idx <= word_idx + 16'd1;
            end
          end
        end
        ST_DATA: begin
          if (byte_fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ s_data;
`endif
          end
          if (word_valid) begin
            // Words beyond the memory depth are consumed but not written.
            if ({1'b0, word_idx} < NUM_LIM) begin
              mem_we       <= 1'b1;
              mem_addr     <= word_idx[ADDR_W-1:0];
              mem_wdata    <= word;
              words_loaded <= words_loaded + 16'd1;
            end else begin
              err <= 1'b1;
            end
            word_idx <= word_idx + 16'd1;
            if (word_idx == n_words - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= ST_CSUM;
`else
              state <= ST_DONE;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (byte_fire) begin
            if (s_data != csum) err <= 1'b1;
            state <= ST_DONE;
          end
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (NUM_INST=4 so overflow is reachable); writes
// are captured into got_q and checked against exp_q inside each test task.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int NI = 4;
  localparam int AW = 2;
  localparam int W  = AW + 32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int ready_drop = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [7:0]   tx_q[$];

  imem_loader #(.NUM_INST(NI), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .state        (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (rst_n && mem_we) got_q.push_back({mem_addr, mem_wdata});
    if (rst_n && done) done_cnt++;
  end

  // Driver tasks
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!s_ready) begin
      errors++;
      $display("FAIL send_byte_timeout: s_ready=%b required=1 byte=%h", s_ready, b);
      s_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  function automatic logic [7:0] tx_xor();
    logic [7:0] x = 8'd0;
    foreach (tx_q[i]) x ^= tx_q[i];
    return x;
  endfunction

  task automatic stream(input int gap, input bit poke_start);
    foreach (tx_q[i]) begin
      send_byte(tx_q[i]);
      if (gap > 0) begin
        s_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          if (poke_start && i == 3 && g == 0) start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          if (busy && !s_ready) ready_drop++;
        end
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (tx_q.size() > 2) send_byte(tx_xor());
`endif
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle_timeout: busy=%b required=0", busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic load_basic_bytes();
    tx_q = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h40, 8'h00, 8'h37, 8'h83, 8'h67, 8'h45};
    exp_q = '{{2'd0, 32'h00400293}, {2'd1, 32'h45678337}};
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_ready, mem_we, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got=%b required=00000", {s_ready, mem_we, busy, done, err});
    end
    checks++;
    if ({mem_addr, mem_wdata, words_loaded} !== '0) begin
      errors++;
      $display("FAIL reset_regs: addr=%h wdata=%h words=%0d required=0", mem_addr, mem_wdata, words_loaded);
    end
    checks++;
    if (state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got=%0d required=%0d", state, ST_IDLE);
    end
  endtask

  task automatic test_basic();
    got_q.delete(); done_cnt = 0;
    load_basic_bytes();
    s_valid = 1'b1; s_data = 8'hA5;
    repeat (3) @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: s_ready=%b busy=%b required=0 0", s_ready, busy);
    end
    s_valid = 1'b0;
    do_start();
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy=%b s_ready=%b required=1 1", busy, s_ready);
    end
    for (int i = 0; i < 6; i++) send_byte(tx_q[i]);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'h00400293) begin
      errors++;
      $display("FAIL basic_word0_latency: we=%b addr=%h data=%h required=1 0 00400293", mem_we, mem_addr, mem_wdata);
    end
    for (int i = 6; i < 10; i++) send_byte(tx_q[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(tx_xor());
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b required=1 0", done, busy);
    end
`else
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_with_write: done=%b busy=%b we=%b required=1 0 1", done, busy, mem_we);
    end
`endif
    s_valid = 1'b0;
    wait_idle();
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL basic_write_count: got=%0d required=2", got_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_write%0d: got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    checks++;
    if (words_loaded !== 16'd2 || err !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL basic_status: words=%0d err=%b dones=%0d required=2 0 1", words_loaded, err, done_cnt);
    end
  endtask

  task automatic test_zero_length();
    got_q.delete(); done_cnt = 0;
    do_start();
    send_byte(8'h00);
    send_byte(8'h00);
    s_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: done=%b required=1", done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_after: busy=%b done=%b required=0 0", busy, done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (got_q.size() != 0 || done_cnt != 1 || words_loaded !== 16'd0) begin
      errors++;
      $display("FAIL zero_status: writes=%0d dones=%0d words=%0d required=0 1 0", got_q.size(), done_cnt, words_loaded);
    end
  endtask

  task automatic test_overflow();
    got_q.delete(); done_cnt = 0;
    tx_q = '{8'h06, 8'h00};
    for (int k = 0; k < 24; k++) tx_q.push_back(8'h10 + 8'(k));
    exp_q = '{{2'd0, 32'h13121110}, {2'd1, 32'h17161514},
              {2'd2, 32'h1B1A1918}, {2'd3, 32'h1F1E1D1C}};
    do_start();
    stream(0, 1'b0);
    wait_idle();
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL overflow_write_count: got=%0d required=4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL overflow_write%0d: got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    checks++;
    if (err !== 1'b1 || words_loaded !== 16'd4 || done_cnt != 1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow_status: err=%b words=%0d dones=%0d s_ready=%b required=1 4 1 0",
               err, words_loaded, done_cnt, s_ready);
    end
  endtask

  task automatic test_gapped();
    got_q.delete(); done_cnt = 0; ready_drop = 0;
    load_basic_bytes();
    do_start();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL gapped_err_cleared: err=%b required=0", err);
    end
    stream(3, 1'b1);
    wait_idle();
    checks++;
    if (ready_drop != 0) begin
      errors++;
      $display("FAIL gapped_ready: drops=%0d required=0", ready_drop);
    end
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL gapped_write_count: got=%0d required=2", got_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gapped_write%0d: got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    checks++;
    if (words_loaded !== 16'd2 || err !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL gapped_status: words=%0d err=%b dones=%0d required=2 0 1", words_loaded, err, done_cnt);
    end
  endtask

  task automatic test_reset_mid_load();
    got_q.delete(); done_cnt = 0;
    load_basic_bytes();
    do_start();
    for (int i = 0; i < 7; i++) send_byte(tx_q[i]);
    s_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || state !== ST_IDLE) begin
      errors++;
      $display("FAIL midreset_state: busy=%b we=%b state=%0d required=0 0 %0d", busy, mem_we, state, ST_IDLE);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL midreset_writes: count=%0d first=%h required=1 %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
    end
    got_q.delete(); done_cnt = 0;
    do_start();
    stream(0, 1'b0);
    wait_idle();
    checks++;
    if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL reload_writes: count=%0d required=2 matching words", got_q.size());
    end
    checks++;
    if (words_loaded !== 16'd2 || err !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL reload_status: words=%0d err=%b dones=%0d required=2 0 1", words_loaded, err, done_cnt);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    got_q.delete(); done_cnt = 0;
    load_basic_bytes();
    do_start();
    foreach (tx_q[i]) send_byte(tx_q[i]);
    send_byte(tx_xor() ^ 8'hFF);
    s_valid = 1'b0;
    wait_idle();
    checks++;
    if (err !== 1'b1 || got_q.size() != 2 || words_loaded !== 16'd2) begin
      errors++;
      $display("FAIL csum_bad: err=%b writes=%0d words=%0d required=1 2 2", err, got_q.size(), words_loaded);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_overflow();
    test_gapped();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
